// File: rtl/a_ram_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : a_ram_skew_feeder
// Brief    : Reads operand-A vectors from a_ram and feeds them to the systolic
//            array rows with a per-lane diagonal skew (lane i delayed i cycles).
//            Optional macro A_FEEDER_ZERO_PAD_EN forces invalid lanes to zero.
// Revision : 1.0 - initial release
// ============================================================================
module a_ram_skew_feeder #(
    parameter int INTEGER_BIT      = 7,
    parameter int A_RAM_ADDR_WIDTH = 7,
    parameter int ARRAY_SIZE       = 4,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    output logic                             finish,
    input  logic                             ws_os,
    input  logic [INTEGER_BIT-1:0]           col_size,
    input  logic [INTEGER_BIT-1:0]           row_size,
    input  logic [A_RAM_ADDR_WIDTH-1:0]      a_ram_start_addr,
    output logic                             a_ram_read_req,
    output logic [A_RAM_ADDR_WIDTH-1:0]      a_ram_read_addr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_ram_read_data,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_a_data,
    output logic [ARRAY_SIZE-1:0]            array_a_valid
);

    localparam int                c_SW         = INTEGER_BIT + 1;
    localparam logic [c_SW-1:0]   c_ARRAY_SIZE = c_SW'(ARRAY_SIZE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                  r_state;
    logic                        r_skip;
    logic [c_SW-1:0]             r_v;
    logic [c_SW-1:0]             r_l;
    logic [c_SW-1:0]             r_cnt;
    logic [A_RAM_ADDR_WIDTH-1:0] r_start;
    logic                        r_rd_q;

    logic [c_SW-1:0] w_v;
    logic [c_SW-1:0] w_lane_req;
    logic [c_SW-1:0] w_l;

    always_comb begin
        w_v        = ws_os ? {1'b0, row_size} : {1'b0, col_size};
        w_lane_req = ws_os ? {1'b0, col_size} : {1'b0, row_size};
        w_l        = (w_lane_req > c_ARRAY_SIZE) ? c_ARRAY_SIZE : w_lane_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_skip  <= 1'b0;
            r_v     <= '0;
            r_l     <= '0;
            r_cnt   <= '0;
            r_start <= '0;
        end else if (!enable) begin
            r_state <= S_IDLE;
            r_skip  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if ((w_v == '0) || (w_l == '0)) begin
                        // Empty tile: hold finish off for one cycle so it rises in cycle 1
                        r_state <= S_DONE;
                        r_skip  <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_v     <= w_v;
                        r_l     <= w_l;
                        r_start <= a_ram_start_addr;
                    end
                end
                S_READ: begin
                    if (r_cnt + 1'b1 == r_v) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == r_l) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_skip <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        a_ram_read_req  = (r_state == S_READ);
        a_ram_read_addr = a_ram_read_req ? (r_start + A_RAM_ADDR_WIDTH'(r_cnt)) : '0;
        finish          = (r_state == S_DONE) && !r_skip;
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_rd_q <= 1'b0;
        end else begin
            r_rd_q <= a_ram_read_req;
        end
    end

    // Data stages load only behind a valid beat, so idle lanes keep their last value
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        localparam logic [c_SW-1:0] c_LANE = c_SW'(i);

        logic [DATA_WIDTH-1:0] r_d [0:i];
        logic [i:0]            r_vld;
        logic                  w_lane_en;

        assign w_lane_en = r_rd_q && (c_LANE < r_l);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= '0;
                for (int j = 0; j <= i; j++) begin
                    r_d[j] <= '0;
                end
            end else if (!enable) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_lane_en;
                if (w_lane_en) begin
                    r_d[0] <= a_ram_read_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
                for (int j = 1; j <= i; j++) begin
                    r_vld[j] <= r_vld[j-1];
                    if (r_vld[j-1]) begin
                        r_d[j] <= r_d[j-1];
                    end
                end
            end
        end

        assign array_a_valid[i] = r_vld[i];
`ifdef A_FEEDER_ZERO_PAD_EN
        assign array_a_data[i*DATA_WIDTH +: DATA_WIDTH] = r_vld[i] ? r_d[i] : '0;
`else
        assign array_a_data[i*DATA_WIDTH +: DATA_WIDTH] = r_d[i];
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_a_ram_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_ram_skew_feeder
// Brief    : Table-driven self-checking bench for a_ram_skew_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_ram_skew_feeder;

    localparam int IB = 7;
    localparam int AW = 7;
    localparam int AS = 4;
    localparam int DW = 8;
    localparam int NCYC = 16;

    localparam int K_REQ   = 0;
    localparam int K_ADDR  = 1;
    localparam int K_VALID = 2;
    localparam int K_DATA  = 3;
    localparam int K_FIN   = 4;

`ifdef A_FEEDER_ZERO_PAD_EN
    localparam int c_PAD_EXP = 0;
`else
    localparam int c_PAD_EXP = 'h23;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              finish;
    logic              ws_os;
    logic [IB-1:0]     col_size;
    logic [IB-1:0]     row_size;
    logic [AW-1:0]     start_addr;
    logic              read_req;
    logic [AW-1:0]     read_addr;
    logic [AS*DW-1:0]  read_data;
    logic [AS*DW-1:0]  a_data;
    logic [AS-1:0]     a_valid;

    logic [AS*DW-1:0]  mem [0:127];

    always #5 clk = ~clk;

    a_ram_skew_feeder #(
        .INTEGER_BIT(IB), .A_RAM_ADDR_WIDTH(AW), .ARRAY_SIZE(AS), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .finish(finish), .ws_os(ws_os),
        .col_size(col_size), .row_size(row_size), .a_ram_start_addr(start_addr),
        .a_ram_read_req(read_req), .a_ram_read_addr(read_addr),
        .a_ram_read_data(read_data), .array_a_data(a_data), .array_a_valid(a_valid)
    );

    // a_ram model: one-cycle read latency
    always @(posedge clk) begin
        if (read_req) read_data <= mem[read_addr];
    end

    typedef struct {
        int tile;
        int cyc;
        int kind;
        int lane;
        int exp;
    } vec_t;

    vec_t vecs[$];
    int nchk = 0;
    int nerr = 0;

    logic          lreq  [0:NCYC-1];
    logic [AW-1:0] laddr [0:NCYC-1];
    logic [AS-1:0] lval  [0:NCYC-1];
    logic [31:0]   ldata [0:NCYC-1];
    logic          lfin  [0:NCYC-1];

    task automatic chk(input string nm, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic add(input int t, input int c, input int k, input int l, input int e);
        vec_t v;
        v.tile = t; v.cyc = c; v.kind = k; v.lane = l; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic set_tile(input logic ws, input int row, input int col, input int st);
        ws_os      = ws;
        row_size   = IB'(row);
        col_size   = IB'(col);
        start_addr = AW'(st);
    endtask

    // Called at a negedge; logs cycles 0..NCYC-1 then drops enable for one edge
    task automatic run_tile(input logic ws, input int row, input int col, input int st);
        set_tile(ws, row, col, st);
        enable = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            lreq[c]  = read_req;
            laddr[c] = read_addr;
            lval[c]  = a_valid;
            ldata[c] = a_data;
            lfin[c]  = finish;
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_tile(input int t);
        int got;
        string kn;
        foreach (vecs[i]) begin
            if (vecs[i].tile == t) begin
                case (vecs[i].kind)
                    K_REQ:   begin got = int'(lreq[vecs[i].cyc]);  kn = "req";   end
                    K_ADDR:  begin got = int'(laddr[vecs[i].cyc]); kn = "addr";  end
                    K_VALID: begin got = int'(lval[vecs[i].cyc]);  kn = "valid"; end
                    K_DATA:  begin got = int'(ldata[vecs[i].cyc][vecs[i].lane*DW +: DW]); kn = "data"; end
                    default: begin got = int'(lfin[vecs[i].cyc]);  kn = "finish"; end
                endcase
                chk($sformatf("tile%0d cyc%0d %s lane%0d", t, vecs[i].cyc, kn, vecs[i].lane),
                    got, vecs[i].exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = '0;
        mem[5]   = 32'h03020100;
        mem[6]   = 32'h13121110;
        mem[7]   = 32'h23222120;
        mem[0]   = 32'hA3A2A1A0;
        mem[1]   = 32'hB3B2B1B0;
        mem[126] = 32'hC3C2C1C0;
        mem[127] = 32'hD3D2D1D0;
        read_data = '0;

        // Tile 0: WS full tile (V=3, L=4)
        add(0, 0, K_REQ, 0, 1);   add(0, 1, K_REQ, 0, 1);   add(0, 2, K_REQ, 0, 1);
        add(0, 3, K_REQ, 0, 0);
        add(0, 0, K_ADDR, 0, 5);  add(0, 1, K_ADDR, 0, 6);  add(0, 2, K_ADDR, 0, 7);
        add(0, 1, K_VALID, 0, 'h0); add(0, 2, K_VALID, 0, 'h1); add(0, 3, K_VALID, 0, 'h3);
        add(0, 4, K_VALID, 0, 'h7); add(0, 5, K_VALID, 0, 'hE); add(0, 6, K_VALID, 0, 'hC);
        add(0, 7, K_VALID, 0, 'h8); add(0, 8, K_VALID, 0, 'h0);
        add(0, 2, K_DATA, 0, 'h00); add(0, 3, K_DATA, 0, 'h10); add(0, 4, K_DATA, 0, 'h20);
        add(0, 5, K_DATA, 3, 'h03); add(0, 6, K_DATA, 3, 'h13); add(0, 7, K_DATA, 3, 'h23);
        add(0, 7, K_FIN, 0, 0);   add(0, 8, K_FIN, 0, 1);   add(0, 12, K_FIN, 0, 1);
        // Tile 1: OS partial lanes (V=2, L=3)
        add(1, 0, K_REQ, 0, 1);   add(1, 1, K_REQ, 0, 1);   add(1, 2, K_REQ, 0, 0);
        add(1, 0, K_ADDR, 0, 0);  add(1, 1, K_ADDR, 0, 1);
        add(1, 2, K_VALID, 0, 'h1); add(1, 3, K_VALID, 0, 'h3); add(1, 4, K_VALID, 0, 'h6);
        add(1, 5, K_VALID, 0, 'h4); add(1, 6, K_VALID, 0, 'h0);
        add(1, 4, K_DATA, 2, 'hA2); add(1, 5, K_DATA, 2, 'hB2);
        add(1, 5, K_DATA, 3, c_PAD_EXP);
        add(1, 5, K_FIN, 0, 0);   add(1, 6, K_FIN, 0, 1);
        // Tile 2: row_size=0 in WS gives L=0
        add(2, 0, K_REQ, 0, 0);   add(2, 1, K_REQ, 0, 0);   add(2, 3, K_REQ, 0, 0);
        add(2, 2, K_VALID, 0, 0);
        add(2, 0, K_FIN, 0, 0);   add(2, 1, K_FIN, 0, 1);
        // Tile 3: address wrap (V=3, L=1, start=126)
        add(3, 0, K_ADDR, 0, 126); add(3, 1, K_ADDR, 0, 127); add(3, 2, K_ADDR, 0, 0);
        add(3, 3, K_REQ, 0, 0);
        add(3, 2, K_VALID, 0, 1); add(3, 4, K_VALID, 0, 1); add(3, 5, K_VALID, 0, 0);
        add(3, 2, K_DATA, 0, 'hC0); add(3, 3, K_DATA, 0, 'hD0); add(3, 4, K_DATA, 0, 'hA0);
        add(3, 4, K_FIN, 0, 0);   add(3, 5, K_FIN, 0, 1);

        rst = 1'b1; enable = 1'b0;
        set_tile(1'b0, 4, 3, 5);
        repeat (3) @(negedge clk);
        chk("reset req",    int'(read_req),  0);
        chk("reset addr",   int'(read_addr), 0);
        chk("reset valid",  int'(a_valid),   0);
        chk("reset data",   int'(a_data),    0);
        chk("reset finish", int'(finish),    0);
        rst = 1'b0;
        @(negedge clk);

        run_tile(1'b0, 4, 3, 5);   check_tile(0);
        run_tile(1'b1, 2, 3, 0);   check_tile(1);
        run_tile(1'b0, 0, 3, 5);   check_tile(2);
        run_tile(1'b0, 1, 3, 126); check_tile(3);

        // Reset mid-tile with enable held high
        set_tile(1'b0, 4, 3, 5);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid c2 addr", int'(read_addr), 7);
        chk("rstmid c2 valid", int'(a_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid valid", int'(a_valid), 0);
        chk("rstmid req",   int'(read_req), 0);
        chk("rstmid data",  int'(a_data),   0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid restart req",  int'(read_req),  1);
        chk("rstmid restart addr", int'(read_addr), 5);
        @(negedge clk);
        chk("rstmid restart addr2", int'(read_addr), 6);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Abort in the first DRAIN cycle, then replay the full tile
        set_tile(1'b0, 4, 3, 5);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort c3 req",   int'(read_req), 0);
        chk("abort c3 valid", int'(a_valid),  3);
        enable = 1'b0;
        @(negedge clk);
        chk("abort valid", int'(a_valid), 0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("abort finish idle%0d", c), int'(finish), 0);
            @(negedge clk);
        end
        run_tile(1'b0, 4, 3, 5);   check_tile(0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/a_ram_skew_feeder.md
# a_ram_skew_feeder

Reads operand-A vectors out of the local a_ram and drives them into the systolic array's row inputs with the diagonal skew the array needs. It is one lane per array row, and lane i is delayed i cycles. It sits directly downstream of the a_ram fill stage: once the a_ram has been filled for a tile, the controller raises `enable` on this block. It uses the same enable/finish level protocol and the same WS/OS size convention as the rest of the datapath.

## Interface
- INTEGER_BIT, 7, width of size fields
- A_RAM_ADDR_WIDTH, 7, a_ram address width
- ARRAY_SIZE, 4, number of array rows (lanes)
- DATA_WIDTH, 8, element width
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  level; high runs one tile, low aborts and returns to idle
- finish  out  1  high from tile completion while `enable` stays high
- ws_os  in  1  0 = WS, 1 = OS
- col_size  in  INTEGER_BIT  tile column count
- row_size  in  INTEGER_BIT  tile row count
- a_ram_start_addr  in  A_RAM_ADDR_WIDTH  first a_ram vector address
- a_ram_read_req  out  1  a_ram read strobe
- a_ram_read_addr  out  A_RAM_ADDR_WIDTH  a_ram read address
- a_ram_read_data  in  ARRAY_SIZE*DATA_WIDTH  vector returned one cycle after the strobe; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
- array_a_data  out  ARRAY_SIZE*DATA_WIDTH  skewed lane data into the array
- array_a_valid  out  ARRAY_SIZE  per-lane valid

## Operation
- **Vector count V and lane count L:**
  - WS: V = col_size, L = min(row_size, ARRAY_SIZE).
  - OS: V = row_size, L = min(col_size, ARRAY_SIZE).
- **FSM states and transitions:**
  - IDLE → READ when `enable`=1, `finish`=0, V≠0 and L≠0.
  - IDLE → DONE when `enable`=1 and either V=0 or L=0. No read is issued in this case.
  - READ lasts V cycles, k = 0..V-1. In cycle k: `a_ram_read_req`=1 and `a_ram_read_addr` = a_ram_start_addr + k. The addition is truncated to A_RAM_ADDR_WIDTH and wraps.
  - READ → DRAIN after cycle V-1.
  - DRAIN lasts L+1 cycles, then → DONE.
  - In DONE, `finish`=1.
  - DONE → IDLE when `enable`=0.
  - Any state → IDLE when `enable`=0. On abort, all skew stages clear on the same edge.
- **Datapath:**
  - The returned vector is captured into an input register.
  - Lane i then passes through i additional shift stages.
  - Lanes ≥ L never assert valid.
- V, L and the start address are latched on the IDLE→READ transition. Input changes mid-tile are ignored.
- Size arithmetic uses INTEGER_BIT+1 bits internally. The end-of-phase compares do not overflow.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all skew/valid registers are 0.
- Numbering: cycle 0 is the first READ cycle, i.e. the cycle after the edge that samples `enable`=1 in IDLE.
- **Read and lane latency:**
  - The read for vector k is issued in cycle k.
  - Its data appears on `a_ram_read_data` in cycle k+1.
  - Lane i shows element i of vector k on `array_a_data` with `array_a_valid[i]`=1 in cycle k+2+i.
- **Finish latency:**
  - The last valid beat is in cycle V+L.
  - `finish` rises in cycle V+L+1.
  - When V=0 or L=0, `finish` rises in cycle 1 instead.
- **Restart after `finish`:** a new tile needs `enable` low for at least one cycle.
- **Reset mid-operation:**
  - `rst` overrides everything. Outputs are 0 in the cycle after the reset edge.
  - If `enable` is still high, a new tile starts on the first edge after `rst` falls.
- **Simultaneous events:** `rst` and `enable` falling together is treated as a reset.

## Configuration
- `A_FEEDER_ZERO_PAD_EN` defined: any lane with valid=0 drives zero on `array_a_data`, so the array sees clean zero padding.
- Not defined: an invalid lane keeps its last registered value. Consumers must qualify that lane with `array_a_valid`. This saves the output muxes.

## Test plan
- **WS full tile:** ws_os=0, row_size=4, col_size=3, start=5, a_ram[5..7] = {0x03020100, 0x13121110, 0x23222120}.
  - read_req in cycles 0-2 with addr 5, 6, 7.
  - Lane 0 emits 00, 10, 20 in cycles 2-4.
  - Lane 3 emits 03, 13, 23 in cycles 5-7.
  - finish rises in cycle 8.
- **OS partial lanes:** ws_os=1, row_size=2, col_size=3, start=0.
  - V=2, L=3.
  - `array_a_valid[3]` stays 0 throughout.
  - Lane 2 is valid in cycles 4-5.
  - finish rises in cycle 6.
- **Zero size and wrap-around:**
  - row_size=0: no read_req ever, finish rises in cycle 1.
  - start=126, V=3: read addresses are 126, 127, 0.
- **Reset mid-tile:** rst pulsed in cycle 2 of the WS case, with `enable` held high.
  - All valids are 0 the next cycle.
  - After rst falls, read_req restarts at addr 5.
- **Abort:** `enable` dropped in the first DRAIN cycle.
  - All valids are 0 the next cycle.
  - finish never rises.
  - Raising `enable` again replays the full tile.
- **Macro:** run the OS case with and without `A_FEEDER_ZERO_PAD_EN`.
  - With the macro: lane 3 data is 0.
  - Without it: lane 3 data holds its previous value.
